// File: rtl/tick_serializer.sv
// Tick-paced serializer: frames a parallel word as start bit, LSB-first data,
// optional even parity (compiled in when PARITY_EN is defined) and stop bit.
module tick_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_DATA,
`ifdef PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sout_q, sout_d;
    logic              done_q, done_d;
`ifdef PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign din_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign sout      = sout_q;
    assign done      = done_q;

    always_comb begin
        // NOTE: every _d takes its held value first so no path through the case infers a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sout_d    = sout_q;
        done_d    = 1'b0;
`ifdef PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                sout_d = 1'b1;
                if (din_valid && din_ready) begin
                    shift_d   = din;
                    bit_cnt_d = '0;
`ifdef PARITY_EN
                    parity_d  = ^din;
`endif
                    state_d   = S_ARMED;
                end
            end
            S_ARMED: begin
                if (tick) begin
                    sout_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    sout_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q < CNT_W'(DATA_W)) begin
                        sout_d    = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
`ifdef PARITY_EN
                        sout_d  = parity_q;
                        state_d = S_PARITY;
`else
                        sout_d  = 1'b1;
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    sout_d  = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    sout_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                sout_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sout_q    <= 1'b1;
            done_q    <= 1'b0;
`ifdef PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sout_q    <= sout_d;
            done_q    <= done_d;
`ifdef PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_tick_serializer.sv
// Scoreboard bench for tick_serializer: stimulus queues expected line events,
// a monitor pops and compares them on every tick edge while the DUT is busy.
module tb_tick_serializer;

    localparam int DATA_W = 8;
`ifdef PARITY_EN
    localparam int FRAME_EV = DATA_W + 4;
`else
    localparam int FRAME_EV = DATA_W + 3;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              sout;
    logic              busy;
    logic              done;
    logic              tick_en;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic is_done;
        logic bit_v;
    } ev_t;

    ev_t exp_q[$];

    tick_serializer #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-clk tick every 4 clks, driven at the falling edge.
    initial begin
        logic [1:0] ph;
        ph   = 2'd0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            ph   = ph + 2'd1;
            tick = tick_en && (ph == 2'd0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity values are hand-computed by the caller from the vector table.
    task automatic push_frame(input logic [DATA_W-1:0] d, input logic par);
        exp_q.push_back('{is_done: 1'b0, bit_v: 1'b0});
        for (int i = 0; i < DATA_W; i++)
            exp_q.push_back('{is_done: 1'b0, bit_v: d[i]});
`ifdef PARITY_EN
        exp_q.push_back('{is_done: 1'b0, bit_v: par});
`else
        if (par === 1'bx) $display("parity unused");
`endif
        exp_q.push_back('{is_done: 1'b0, bit_v: 1'b1});
        exp_q.push_back('{is_done: 1'b1, bit_v: 1'b1});
    endtask

    // Monitor: samples just before each rising edge, compares 1 time unit after it.
    initial begin
        logic t_s, r_s, b_s, so_s, done_ok;
        ev_t  ev;
        forever begin
            @(negedge clk);
            #4;
            t_s  = tick;
            r_s  = rst;
            b_s  = busy;
            so_s = sout;
            @(posedge clk);
            #1;
            done_ok = 1'b0;
            if (!r_s) begin
                if (t_s && b_s) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: sout=%0b done=%0b with empty scoreboard at %0t",
                                 sout, done, $time);
                    end else begin
                        ev = exp_q.pop_front();
                        if (ev.is_done) begin
                            check("done_pulse", done, 1);
                            check("busy_at_done", busy, 0);
                            check("sout_at_done", sout, 1);
                            done_ok = 1'b1;
                        end else begin
                            check("line_bit", sout, ev.bit_v);
                            check("busy_mid_frame", busy, 1);
                        end
                    end
                end else begin
                    check("sout_hold", sout, so_s);
                end
                if (done && !done_ok) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_done: done=1 unexpectedly at %0t", $time);
                end
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input logic par);
        int n;
        n = 0;
        @(negedge clk);
        while (!din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", din_ready, 1);
        din       = d;
        din_valid = 1'b1;
        push_frame(d, par);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int base;
        rst       = 1'b1;
        tick_en   = 1'b0;
        din       = '0;
        din_valid = 1'b0;

        // Reset held for two clocks.
        @(negedge clk);
        @(negedge clk);
        check("rst_sout", sout, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", din_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", din_ready, 1);
        tick_en = 1'b1;

        // Plain frames: 8'hA5 line 0,1,0,1,0,0,1,0,1,[0],1 ; 8'h07 parity 1.
        send(8'hA5, 1'b0);
        drain();
        send(8'h07, 1'b1);
        drain();

        // A word offered mid-frame is refused and never sent.
        send(8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        din       = 8'h3C;
        din_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ready_low_busy", din_ready, 0);
        end
        din_valid = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // Reset one clk after tick 5 of an 8'h00 frame, then a clean 8'hFF frame.
        send(8'h00, 1'b0);
        base = exp_q.size();
        n = 0;
        while (exp_q.size() > base - 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tick5_reached", exp_q.size(), base - 5);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("ready_in_rst", din_ready, 0);
        @(posedge clk);
        #1;
        check("abort_sout", sout, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_abort", din_ready, 1);
        repeat (12) @(negedge clk);
        send(8'hFF, 1'b0);
        drain();

        // Accept on a tick edge, then back-to-back words with din_valid held.
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!tick && n < 20);
        check("found_tick", tick, 1);
        din       = 8'h01;
        din_valid = 1'b1;
        push_frame(8'h01, 1'b1);
        @(posedge clk);
        #1;
        check("accept_on_tick_busy", busy, 1);
        check("accept_on_tick_sout", sout, 1);
        @(negedge clk);
        din = 8'h80;
        push_frame(8'h80, 1'b1);
        check("sout_wait_tick", sout, 1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 300);
        check("first_done_seen", done, 1);
        check("ready_at_done", din_ready, 1);
        @(posedge clk);
        #1;
        check("second_accept", busy, 1);
        @(negedge clk);
        din_valid = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
